// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/TRAP FSM with stall, jump, branch and misaligned-redirect trap.
// Define PC_SEQ_RVC_EN to relax target alignment to 2 bytes for compressed instructions.
module pc_sequencer #(
  parameter int          N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = '0,
  parameter logic [N-1:0] TRAP_VECTOR  = N'('h100)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         jump,
  input  logic [N-1:0] jump_target,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         trap_ack,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic         fetch_valid,
  output logic         misalign_trap,
  output logic [N-1:0] epc
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_TRAP
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] epc_q, epc_d;
  logic         trap_q, trap_d;

  logic         redir;
  logic [N-1:0] tgt;
  logic         misal;

  assign pc_plus4 = pc_q + N'(4);

  // Only the winning redirect source is considered for alignment.
  always_comb begin
    redir = 1'b0;
    tgt   = '0;
    if (jump) begin
      redir = 1'b1;
      tgt   = jump_target;
    end else if (branch_taken) begin
      redir = 1'b1;
      tgt   = branch_target;
    end
  end

`ifdef PC_SEQ_RVC_EN
  assign misal = tgt[0];
`else
  assign misal = |tgt[1:0];
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    trap_d  = trap_q;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        pc_d    = RESET_VECTOR;
      end
      S_RUN: begin
        if (!stall) begin
          if (redir && misal) begin
            epc_d   = tgt;
            pc_d    = TRAP_VECTOR;
            trap_d  = 1'b1;
            state_d = S_TRAP;
          end else if (redir) begin
            pc_d = tgt;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      S_TRAP: begin
        if (trap_ack) begin
          trap_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      trap_q  <= trap_d;
    end
  end

  assign pc            = pc_q;
  assign fetch_valid   = (state_q == S_RUN);
  assign misalign_trap = trap_q;
  assign epc           = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: reference model plus directed vectors.
// Honours PC_SEQ_RVC_EN when the same define is passed to the build.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0;
  localparam logic [31:0] TV = 32'h100;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        misalign_trap;
  logic [31:0] epc;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .trap_ack     (trap_ack),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .misalign_trap(misalign_trap),
    .epc          (epc)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bad(input logic [31:0] a);
`ifdef PC_SEQ_RVC_EN
    return (a % 2) != 0;
`else
    return (a % 4) != 0;
`endif
  endfunction

  // Reference model: booting / trapped flags and architectural registers.
  bit          m_boot = 1;
  bit          m_trap = 0;
  logic [31:0] m_pc   = RV;
  logic [31:0] m_epc  = 0;
  logic [31:0] m_t;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot = 1;
      m_trap = 0;
      m_pc   = RV;
      m_epc  = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_trap) begin
      if (trap_ack) m_trap = 0;
    end else if (!stall) begin
      if (jump || branch_taken) begin
        m_t = jump ? jump_target : branch_target;
        if (bad(m_t)) begin
          m_epc  = m_t;
          m_pc   = TV;
          m_trap = 1;
        end else begin
          m_pc = m_t;
        end
      end else begin
        m_pc = 32'((longint'(m_pc) + 4) % 64'h1_0000_0000);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_pc", pc, m_pc);
      chk("m_pc_plus4", pc_plus4,
          32'((longint'(m_pc) + 4) % 64'h1_0000_0000));
      chk("m_fetch_valid", 32'(fetch_valid), 32'(!m_boot && !m_trap));
      chk("m_misalign_trap", 32'(misalign_trap), 32'(m_trap));
      chk("m_epc", epc, m_epc);
    end
  end

  initial begin
    rst_n = 1;
    stall = 0;
    jump = 0;
    jump_target = 0;
    branch_taken = 0;
    branch_target = 0;
    trap_ack = 0;
    #2 rst_n = 0;
    cmp_en = 1;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 0);
    chk("rst_trap", 32'(misalign_trap), 0);
    chk("rst_epc", epc, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("boot_fv", 32'(fetch_valid), 0);
    chk("boot_pc", pc, 32'h0);
    @(negedge clk);
    chk("run0_pc", pc, 32'h0);
    chk("run0_fv", 32'(fetch_valid), 1);
    @(negedge clk);
    chk("run1_pc", pc, 32'h4);
    trap_ack = 1;
    @(negedge clk);
    chk("run2_pc", pc, 32'h8);
    chk("ack_noeff", 32'(misalign_trap), 0);
    trap_ack = 0;
    jump = 1;
    jump_target = 32'h40;
    branch_taken = 1;
    branch_target = 32'h80;
    @(negedge clk);
    chk("jmp_prio", pc, 32'h40);
    branch_taken = 0;
    jump_target = 32'h10;
    @(negedge clk);
    chk("jmp_10", pc, 32'h10);
    jump = 0;
    stall = 1;
    branch_taken = 1;
    branch_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", pc, 32'h10);
    end
    stall = 0;
    @(negedge clk);
    chk("stall_rel", pc, 32'h200);
    jump = 1;
    jump_target = 32'h300;
    branch_target = 32'h102;
    @(negedge clk);
    chk("lose_misal_pc", pc, 32'h300);
    chk("lose_misal_trap", 32'(misalign_trap), 0);
    jump = 0;
    @(negedge clk);
    branch_taken = 0;
`ifdef PC_SEQ_RVC_EN
    chk("rvc_pc", pc, 32'h102);
    chk("rvc_trap", 32'(misalign_trap), 0);
    @(negedge clk);
    chk("rvc_next", pc, 32'h106);
`else
    chk("trap_pc", pc, 32'h100);
    chk("trap_flag", 32'(misalign_trap), 1);
    chk("trap_epc", epc, 32'h102);
    chk("trap_fv", 32'(fetch_valid), 0);
    stall = 1;
    jump = 1;
    jump_target = 32'h400;
    @(negedge clk);
    chk("trap_ign_pc", pc, 32'h100);
    chk("trap_ign_fv", 32'(fetch_valid), 0);
    stall = 0;
    jump = 0;
    trap_ack = 1;
    @(negedge clk);
    trap_ack = 0;
    chk("ack_pc", pc, 32'h100);
    chk("ack_fv", 32'(fetch_valid), 1);
    chk("ack_trap", 32'(misalign_trap), 0);
    chk("ack_epc", epc, 32'h102);
    @(negedge clk);
    chk("ack_next", pc, 32'h104);
`endif
    jump = 1;
    jump_target = 32'hFFFF_FFFC;
    @(negedge clk);
    jump = 0;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_p4", pc_plus4, 32'h0);
    @(negedge clk);
    chk("wrap_next", pc, 32'h0);
    chk("wrap_noflag", 32'(misalign_trap), 0);
    jump = 1;
    jump_target = 32'h203;
    @(negedge clk);
    jump = 0;
    chk("jtrap_pc", pc, 32'h100);
    chk("jtrap_epc", epc, 32'h203);
    chk("jtrap_p4", pc_plus4, 32'h104);
    stall = 1;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_epc", epc, 32'h0);
    chk("mid_rst_trap", 32'(misalign_trap), 0);
    chk("mid_rst_fv", 32'(fetch_valid), 0);
    stall = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("reboot_fv", 32'(fetch_valid), 0);
    @(negedge clk);
    chk("reboot_pc0", pc, 32'h0);
    chk("reboot_fv1", 32'(fetch_valid), 1);
    @(negedge clk);
    chk("reboot_pc4", pc, 32'h4);
    @(negedge clk);
    chk("reboot_pc8", pc, 32'h8);
    #1;
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter N, default 32, datapath width of PC and targets.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100, PC loaded on misaligned redirect.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  hold current PC (RUN state only).
REQ-007 jump  in  1  unconditional redirect request.
REQ-008 jump_target  in  N  jump destination.
REQ-009 branch_taken  in  1  conditional redirect request.
REQ-010 branch_target  in  N  branch destination.
REQ-011 trap_ack  in  1  trap handler acknowledge; releases TRAP state.
REQ-012 pc  out  N  current fetch address (registered).
REQ-013 pc_plus4  out  N  combinational pc + 4, modulo 2^N.
REQ-014 fetch_valid  out  1  pc is a valid fetch address this cycle.
REQ-015 misalign_trap  out  1  misaligned redirect trap pending.
REQ-016 epc  out  N  captured offending target address.

Function
REQ-017 FSM states SHALL be BOOT, RUN and TRAP.
REQ-018 BOOT: fetch_valid=0 and pc=RESET_VECTOR; the block SHALL move unconditionally to RUN on the next edge.
REQ-019 RUN: fetch_valid=1; next-PC priority SHALL be stall (hold) > jump > branch_taken > pc_plus4.
REQ-020 While stall=1, jump and branch_taken SHALL be ignored; requesters hold them until stall drops.
REQ-021 Redirect latency SHALL be one cycle: a request sampled at edge k appears on pc after edge k.
REQ-022 A selected target is misaligned when target[1:0]!=0. A misaligned target SHALL NOT be loaded. Instead: epc<=target, pc<=TRAP_VECTOR, misalign_trap<=1, state->TRAP.
REQ-023 The misalignment check SHALL apply only to the winning source; a misaligned branch_target with jump=1 SHALL NOT trap.
REQ-024 TRAP: fetch_valid=0, pc holds TRAP_VECTOR, and stall/jump/branch SHALL be ignored.
REQ-025 In TRAP, trap_ack=1 SHALL clear misalign_trap and return to RUN, with the first fetch at TRAP_VECTOR. epc SHALL hold its value until the next trap.
REQ-026 trap_ack outside TRAP SHALL have no effect.
REQ-027 Sequential increment SHALL wrap silently (N'hFFFF_FFFC -> 0), with no flag.
REQ-028 pc_plus4 SHALL be valid in every state, including BOOT and TRAP.

Reset
REQ-029 rst_n=0 SHALL immediately set state=BOOT, pc=RESET_VECTOR, fetch_valid=0, misalign_trap=0 and epc=0, independent of clk.
REQ-030 Reset asserted mid-TRAP or mid-stall SHALL abandon the operation. After rst_n rises, BOOT SHALL occupy exactly one cycle.
REQ-031 Reset deassertion SHALL take effect only on a clk rising edge.

Configuration
REQ-032 Macro PC_SEQ_RVC_EN SHALL be defined to enable compressed-instruction alignment.
REQ-033 With PC_SEQ_RVC_EN defined, a target is misaligned only when target[0]!=0.
REQ-034 Without PC_SEQ_RVC_EN, a target is misaligned when target[1:0]!=0.
REQ-035 Increment SHALL remain +4 in both builds.

Verification
REQ-036 Release reset with RESET_VECTOR=0 and no requests -> pc sequence 0 (fetch_valid=0), then 0, 4, 8 (fetch_valid=1).
REQ-037 pc=8 with jump=1, jump_target=0x40 and branch_taken=1, branch_target=0x80 in the same cycle -> next pc=0x40.
REQ-038 pc=0x10 with stall=1 for 3 cycles and branch_taken=1, target=0x200 held -> pc stays 0x10 for 3 cycles, then 0x200.
REQ-039 branch_taken=1, target=0x0000_0102, RVC disabled -> pc=0x100, misalign_trap=1, epc=0x102, fetch_valid=0. trap_ack=1 -> RUN with pc 0x100, then 0x104.
REQ-040 Same target 0x102 with PC_SEQ_RVC_EN defined -> no trap, next pc=0x102. Separately, pc=0xFFFF_FFFC with no requests -> next pc=0x0.
REQ-041 Assert rst_n=0 mid-cycle while in TRAP -> outputs reset before the next clk edge, epc=0, then the BOOT-to-RUN sequence of REQ-036.
